// File: rtl/hyper_cordic_rotate.sv
// Iterative hyperbolic CORDIC rotation engine: 16 micro-rotations (shifts 4 and 13 repeated),
// one per clock, with valid/ready handshakes on the operand and result sides.
module hyper_cordic_rotate #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned FRAC   = DWIDTH - 2,
  parameter int unsigned NITER  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] iX,
  input  logic [DWIDTH-1:0] iY,
  input  logic [DWIDTH-1:0] iZ,
  input  logic              iValid,
  output logic              iReady,
  output logic [DWIDTH-1:0] coshOut,
  output logic [DWIDTH-1:0] sinhOut,
  output logic [DWIDTH-1:0] zOut,
  output logic              oValid,
  input  logic              oReady,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(NITER);
  localparam int unsigned ShW  = CntW + 1;
  localparam int unsigned TabN = 2 ** ShW;

  typedef logic signed [DWIDTH-1:0] word_t;
  typedef word_t [TabN-1:0] tab_t;
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  // atanh(2^-s) in Q2.FRAC from the odd power series, 8 guard bits, rounded to nearest
  function automatic word_t atanh_q(int unsigned s);
    longint unsigned acc;
    int unsigned     g;
    g   = FRAC + 8;
    acc = 64'd0;
    if (s != 0) begin
      for (int unsigned k = 1; s * k <= g; k += 2) begin
        acc += (64'd1 << (g - s * k)) / 64'(k);
      end
    end
    return word_t'((acc + 64'd128) >> 8);
  endfunction

  function automatic tab_t build_tab();
    tab_t t;
    for (int unsigned s = 0; s < TabN; s++) begin
      t[s] = atanh_q(s);
    end
    return t;
  endfunction

  localparam tab_t AtanhTab = build_tab();

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  word_t           x_q, x_d, y_q, y_d, z_q, z_d;
  word_t           cosh_q, cosh_d, sinh_q, sinh_d, zo_q, zo_d;

  logic [ShW-1:0]  shift;
  logic            d_pos;
  logic            last;
  word_t           x_sh, y_sh, x_rot, y_rot, z_rot;

  assign last = (cnt_q == CntW'(NITER - 1));

  // Shift schedule 1,2,3,4,4,5,...,13,13,14: index minus the repeats already taken
  always_comb begin
    shift = ShW'(cnt_q) + ShW'(1) - ShW'(cnt_q >= CntW'(4)) - ShW'(cnt_q >= CntW'(NITER - 2));
    d_pos = ~z_q[DWIDTH-1];
    x_sh  = x_q >>> shift;
    y_sh  = y_q >>> shift;
    x_rot = d_pos ? x_q + y_sh : x_q - y_sh;
    y_rot = d_pos ? y_q + x_sh : y_q - x_sh;
    z_rot = d_pos ? z_q - AtanhTab[shift] : z_q + AtanhTab[shift];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (iValid) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  if (oReady) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    iReady = 1'b0;
    oValid = 1'b0;
    busy   = 1'b0;
    unique case (state_q)
      StIdle:  iReady = 1'b1;
      StRun:   busy   = 1'b1;
      StDone:  oValid = 1'b1;
      default: iReady = 1'b0;
    endcase
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    cnt_d  = cnt_q;
    cosh_d = cosh_q;
    sinh_d = sinh_q;
    zo_d   = zo_q;
    unique case (state_q)
      StIdle: begin
        if (iValid) begin
          x_d   = iX;
          y_d   = iY;
          z_d   = iZ;
          cnt_d = '0;
        end
      end
      StRun: begin
        x_d   = x_rot;
        y_d   = y_rot;
        z_d   = z_rot;
        cnt_d = cnt_q + CntW'(1);
        if (last) begin
          cosh_d = x_rot;
          sinh_d = y_rot;
          zo_d   = z_rot;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      cnt_q  <= '0;
      cosh_q <= '0;
      sinh_q <= '0;
      zo_q   <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      cnt_q  <= cnt_d;
      cosh_q <= cosh_d;
      sinh_q <= sinh_d;
      zo_q   <= zo_d;
    end
  end

  assign coshOut = cosh_q;
  assign sinhOut = sinh_q;
  assign zOut    = zo_q;

endmodule

// File: tb/tb_hyper_cordic_rotate.sv
// Directed bench for hyper_cordic_rotate; expected results are hand-iterated CORDIC values
// (floor arithmetic shifts, Q2.14) plus handshake and latency timing.
module tb_hyper_cordic_rotate;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] iX, iY, iZ;
  logic        iValid, iReady;
  logic [15:0] coshOut, sinhOut, zOut;
  logic        oValid, oReady, busy;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [15:0] InvK = 16'd19784;

  hyper_cordic_rotate #(.DWIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .iX      (iX),
    .iY      (iY),
    .iZ      (iZ),
    .iValid  (iValid),
    .iReady  (iReady),
    .coshOut (coshOut),
    .sinhOut (sinhOut),
    .zOut    (zOut),
    .oValid  (oValid),
    .oReady  (oReady),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one job (DUT must be idle), wait for oValid, capture results, take the handshake.
  task automatic do_job(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        output int lat, output logic [15:0] c, output logic [15:0] s,
                        output logic [15:0] zr);
    iX = x; iY = y; iZ = z; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    lat = 0;
    while (oValid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    c = coshOut; s = sinhOut; zr = zOut;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; iValid = 1'b0; oReady = 1'b0;
    iX = '0; iY = '0; iZ = '0;
    tick(); tick();
    rst = 1'b0;
    n_checks++; if (iReady !== 1'b1) begin n_fail++; $display("FAIL reset_iReady: got %b want 1", iReady); end
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_oValid: got %b want 0", oValid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (coshOut !== 16'd0) begin n_fail++; $display("FAIL reset_cosh: got %0d want 0", coshOut); end
    n_checks++; if (sinhOut !== 16'd0) begin n_fail++; $display("FAIL reset_sinh: got %0d want 0", sinhOut); end
    n_checks++; if (zOut !== 16'd0) begin n_fail++; $display("FAIL reset_z: got %0d want 0", zOut); end
  endtask

  task automatic test_positive();
    int lat; logic [15:0] c, s, zr;
    oReady = 1'b1;
    do_job(InvK, 16'd0, 16'd8192, lat, c, s, zr);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL pos_latency: got %0d want 16", lat); end
    n_checks++; if (c !== 16'd18476) begin n_fail++; $display("FAIL pos_cosh: got %0d want 18476", c); end
    n_checks++; if (s !== 16'd8539) begin n_fail++; $display("FAIL pos_sinh: got %0d want 8539", s); end
    n_checks++; if (zr !== 16'hFFFF) begin n_fail++; $display("FAIL pos_z: got %h want ffff", zr); end
    // After the handshake: idle again, results still held
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL pos_oValid_drop: got %b want 0", oValid); end
    n_checks++; if (iReady !== 1'b1) begin n_fail++; $display("FAIL pos_iReady_back: got %b want 1", iReady); end
    n_checks++; if (coshOut !== 16'd18476) begin n_fail++; $display("FAIL pos_cosh_held: got %0d want 18476", coshOut); end
  endtask

  task automatic test_negative_zero();
    int lat; logic [15:0] c, s, zr;
    oReady = 1'b1;
    do_job(InvK, 16'd0, 16'hE000, lat, c, s, zr);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL neg_latency: got %0d want 16", lat); end
    n_checks++; if (c !== 16'd18474) begin n_fail++; $display("FAIL neg_cosh: got %0d want 18474", c); end
    n_checks++; if (s !== 16'hDEA7) begin n_fail++; $display("FAIL neg_sinh: got %h want dea7 (-8537)", s); end
    n_checks++; if (zr !== 16'hFFFF) begin n_fail++; $display("FAIL neg_z: got %h want ffff", zr); end
    do_job(InvK, 16'd0, 16'd0, lat, c, s, zr);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL zero_latency: got %0d want 16", lat); end
    n_checks++; if (c !== 16'd16383) begin n_fail++; $display("FAIL zero_cosh: got %0d want 16383", c); end
    n_checks++; if (s !== 16'd2) begin n_fail++; $display("FAIL zero_sinh: got %0d want 2", s); end
    n_checks++; if (zr !== 16'hFFFF) begin n_fail++; $display("FAIL zero_z: got %h want ffff", zr); end
  endtask

  task automatic test_backpressure();
    int lat; int bad; logic [15:0] c0, s0, z0;
    oReady = 1'b0;
    iX = InvK; iY = 16'd0; iZ = 16'd8192; iValid = 1'b1;
    tick();
    // Next operands presented while busy must not disturb the running job
    iZ = 16'hE000;
    lat = 0;
    while (oValid !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL bp_latency: got %0d want 16", lat); end
    c0 = coshOut; s0 = sinhOut; z0 = zOut;
    bad = 0;
    repeat (10) begin
      tick();
      if (oValid !== 1'b1 || iReady !== 1'b0 || coshOut !== c0 || sinhOut !== s0 || zOut !== z0)
        bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); end
    n_checks++; if (c0 !== 16'd18476) begin n_fail++; $display("FAIL bp_cosh: got %0d want 18476", c0); end
    n_checks++; if (s0 !== 16'd8539) begin n_fail++; $display("FAIL bp_sinh: got %0d want 8539", s0); end
    oReady = 1'b1;
    tick();
    n_checks++; if (oValid !== 1'b0) begin n_fail++; $display("FAIL bp_oValid_drop: got %b want 0", oValid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept_on_handshake: busy got %b want 0", busy); end
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept_next: busy got %b want 1", busy); end
    iValid = 1'b0;
    lat = 0;
    while (oValid !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL bp_job2_latency: got %0d want 16", lat); end
    n_checks++; if (sinhOut !== 16'hDEA7) begin n_fail++; $display("FAIL bp_job2_sinh: got %h want dea7", sinhOut); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat; int seen; logic [15:0] c, s, zr;
    oReady = 1'b1;
    iX = InvK; iY = 16'd0; iZ = 16'd8192; iValid = 1'b1;
    tick();
    iValid = 1'b0;
    repeat (7) tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rm_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy_after: got %b want 0", busy); end
    n_checks++; if (iReady !== 1'b1) begin n_fail++; $display("FAIL rm_iReady: got %b want 1", iReady); end
    n_checks++; if (coshOut !== 16'd0) begin n_fail++; $display("FAIL rm_cosh_cleared: got %0d want 0", coshOut); end
    seen = 0;
    repeat (20) begin tick(); if (oValid !== 1'b0) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rm_no_oValid: got %0d pulses want 0", seen); end
    do_job(InvK, 16'd0, 16'hE000, lat, c, s, zr);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL rm_fresh_latency: got %0d want 16", lat); end
    n_checks++; if (c !== 16'd18474) begin n_fail++; $display("FAIL rm_fresh_cosh: got %0d want 18474", c); end
    n_checks++; if (s !== 16'hDEA7) begin n_fail++; $display("FAIL rm_fresh_sinh: got %h want dea7", s); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [15:0] c, s, zr;
    oReady = 1'b1;
    do_job(InvK, 16'd0, 16'h8000, lat, c, s, zr);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL oor_minneg_latency: got %0d want 16", lat); end
    n_checks++; if (iReady !== 1'b1) begin n_fail++; $display("FAIL oor_minneg_idle: iReady got %b want 1", iReady); end
    do_job(InvK, 16'd0, 16'd24000, lat, c, s, zr);
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL oor_big_latency: got %0d want 16", lat); end
    n_checks++; if (iReady !== 1'b1) begin n_fail++; $display("FAIL oor_big_idle: iReady got %b want 1", iReady); end
  endtask

  task automatic test_back_to_back();
    int first_ov; int acc2; int lat; logic [15:0] ca, sa;
    oReady = 1'b1;
    iX = InvK; iY = 16'd0; iZ = 16'd8192; iValid = 1'b1;
    tick();
    // Second job's operands held with iValid high throughout the first job
    iZ = 16'd0;
    first_ov = -1; acc2 = -1; ca = '0; sa = '0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (oValid === 1'b1 && first_ov < 0) begin first_ov = n; ca = coshOut; sa = sinhOut; end
      if (busy === 1'b1 && first_ov >= 0 && acc2 < 0) acc2 = n;
      if (acc2 >= 0) break;
    end
    n_checks++; if (first_ov !== 16) begin n_fail++; $display("FAIL b2b_first_latency: got %0d want 16", first_ov); end
    n_checks++; if (acc2 !== 18) begin n_fail++; $display("FAIL b2b_second_accept: got %0d want 18", acc2); end
    n_checks++; if (ca !== 16'd18476) begin n_fail++; $display("FAIL b2b_first_cosh: got %0d want 18476", ca); end
    n_checks++; if (sa !== 16'd8539) begin n_fail++; $display("FAIL b2b_first_sinh: got %0d want 8539", sa); end
    iValid = 1'b0;
    lat = 0;
    while (oValid !== 1'b1 && lat < 40) begin tick(); lat++; end
    n_checks++; if (lat !== 16) begin n_fail++; $display("FAIL b2b_second_latency: got %0d want 16", lat); end
    n_checks++; if (coshOut !== 16'd16383) begin n_fail++; $display("FAIL b2b_second_cosh: got %0d want 16383", coshOut); end
    n_checks++; if (sinhOut !== 16'd2) begin n_fail++; $display("FAIL b2b_second_sinh: got %0d want 2", sinhOut); end
    tick();
  endtask

  initial begin
    rst = 1'b1; iValid = 1'b0; oReady = 1'b1;
    iX = '0; iY = '0; iZ = '0;
    test_reset();
    test_positive();
    test_negative_zero();
    test_backpressure();
    test_reset_mid();
    test_out_of_range();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hyper_cordic_rotate.md
Name: hyper_cordic_rotate

Overview:
- Iterative hyperbolic CORDIC rotation engine: the stage directly downstream of the stage-2 sinh pre-scaling block.
- Consumes the pre-scaled coordinate pair (x, y) and the residual angle z produced by stage 2.
- Runs the hyperbolic micro-rotations, including the mandatory repeat iterations 4 and 13, one micro-rotation per clock.
- Returns cosh/sinh of the residual angle through a valid/ready handshake on both sides.

Parameters:
DWIDTH, IDWIDTH, datapath width (signed two's complement, Q2.(DWIDTH-2)); 16-bit accuracy is the target.
FRAC, DWIDTH-2, fractional bits of x, y, z.
NITER, 16, micro-rotation count (shifts 1..14, with 4 and 13 executed twice).

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
iX  input  DWIDTH  initial x (stage-2 output; 1/K pre-scaled)
iY  input  DWIDTH  initial y
iZ  input  DWIDTH  residual angle
iValid  input  1  input operands valid
iReady  output  1  engine can accept operands
coshOut  output  DWIDTH  final x
sinhOut  output  DWIDTH  final y
zOut  output  DWIDTH  final residual angle (near 0 when converged)
oValid  output  1  results valid
oReady  input  1  consumer accepts results
busy  output  1  high in RUN

Behaviour:
- One clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, iReady=1, oValid=0, busy=0, coshOut/sinhOut/zOut=0, iteration counter=0.
- States:
  - IDLE: iReady=1. On iValid&&iReady, load x/y/z from iX/iY/iZ, counter=0, go to RUN. Inputs are sampled only at this edge.
  - RUN: iReady=0, busy=1. Each edge performs one micro-rotation and increments the counter. After the 16th micro-rotation, go to DONE.
  - DONE: oValid=1. Outputs are stable and held while oReady=0. On oValid&&oReady, go to IDLE; oValid falls on that edge.
- Latency:
  - Accept at edge k; micro-rotations at edges k+1..k+16.
  - DONE/oValid observable after edge k+16.
  - Best-case throughput is one result per 18 cycles (accept, 16 RUN, DONE with oReady=1).
- Shift schedule by counter 0..15: s = 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14.
- Micro-rotation:
  - d=+1 if z>=0 (sign bit 0), else -1.
  - x' = x + d*(y>>>s)
  - y' = y + d*(x>>>s)
  - z' = z - d*T[s]
  - All three use pre-update values.
  - >>> is an arithmetic shift on signed values.
  - Add/sub wraps in DWIDTH bits with no saturation (same wrap semantics as fixedAddSub; the implementation may instantiate fixedAddSub).
- atanh table T[s] in Q2.14: 1→9000, 2→4185, 3→2059, 4→1025, 5→512. For s≥6, T[s]=2^(14-s): 256,128,64,32,16,8,4,2,1.
  - For DWIDTH≠16, T is recomputed as round(atanh(2^-s)·2^FRAC).
- Output registers:
  - coshOut/sinhOut/zOut are loaded from x/y/z on the RUN→DONE edge.
  - They hold their values in IDLE until the next RUN→DONE edge.
  - They are not cleared on handshake.
- Boundary conditions:
  - iValid while not IDLE: ignored, with no effect on the current job.
  - oReady=1 in DONE together with iValid=1: DONE→IDLE only. iReady=0 that cycle, so no accept; the new operand is accepted the following cycle at the earliest.
  - oReady outside DONE: ignored.
  - rst asserted in RUN or DONE: next edge is IDLE with reset values; the in-flight job is discarded and no oValid pulse is produced.
  - |iZ| > 1.118 (outside the convergence range): the engine still completes in 16 iterations with the same handshake. Numeric result is unspecified, but no lockup is permitted.
  - iZ = most-negative value: no special case; wraps per the arithmetic rules.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, iValid=0 → iReady=1, oValid=0, busy=0, all outputs 0.
2. Positive angle: iX=19784 (1/K≈1.2075), iY=0, iZ=8192 (0.5), oReady=1 → oValid exactly 16 cycles after the accept edge; coshOut=18475±4, sinhOut=8538±4, |zOut|≤4.
3. Negative angle and zero angle:
   - iZ=-8192 → coshOut=18475±4, sinhOut=-8538±4.
   - iZ=0 → coshOut=16384±4, sinhOut=0±4.
4. Backpressure: oReady=0 for 10 cycles after oValid → outputs and oValid held constant, iReady=0. Then oReady=1 → oValid drops next edge; iValid held high is accepted only on the cycle after that.
5. Reset mid-operation: assert rst at RUN counter=7 → IDLE next edge, oValid never pulses. A fresh job then completes with correct values and unchanged latency.
6. Back-to-back jobs with iValid held high and oReady=1 → second job accepted 18 cycles after the first; iValid during RUN does not corrupt the first job (compare against a bit-accurate model).
